div_seq: RTL and testbench
==========================

# div_seq

Multi-cycle sequencer for MIPS DIV/DIVU in the execute stage. Captures two 32-bit operands on a start request, runs a radix-2 restoring division over 32 cycles, and returns {remainder, quotient} for the HI/LO write path. It raises a stall request so the pipeline controller freezes the front end while the division runs. It also supports annulment, so a division in a squashed slot can be aborted.

## Interface
- DW, 32, operand width; the step counter covers DW steps.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable`).
- start_i  in  1  division request from EX; held high until ready_o is seen.
- annul_i  in  1  abort the current division; wins over start_i.
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  DW  dividend.
- opdata2_i  in  DW  divisor.
- result_o  out  2*DW  {remainder (to HI), quotient (to LO)}; valid only while ready_o=1.
- ready_o  out  1  result valid.
- stall_o  out  1  stall request to the pipeline controller.

## Operation
- States: IDLE, BYZERO, ON, DONE. Reset forces IDLE and result_o=0, ready_o=0, stall_o=0. Reset takes effect in any state, including mid-division.
- **IDLE**
  - start_i=1 and annul_i=0 and opdata2_i=0 → BYZERO.
  - start_i=1 and annul_i=0 and opdata2_i≠0 → ON. Operands are captured in this cycle.
- **Operand capture**
  - If signed_i=1, dividend and divisor are latched as absolute values.
  - Also latched: signed_i, the dividend sign, and the XOR of the two operand signs.
  - Inputs are ignored after capture.
- **ON** (one step per cycle)
  - Each cycle, compute trial = {rem, quo[DW-1]} − {0, divisor}, DW+1 bits.
  - If trial[DW]=0: rem ← trial[DW-1:0], quo ← {quo[DW-2:0], 1}.
  - Otherwise: rem ← {rem[DW-2:0], quo[DW-1]}, quo ← {quo[DW-2:0], 0}.
  - rem starts at 0 and quo starts at the dividend. A 5-bit counter tracks steps from 0 to 31.
  - After step 31, go to DONE. Sign correction is applied on the same edge:
    - quotient is negated if the operand signs differed;
    - remainder is negated if the dividend was negative;
    - both apply only for signed operations.
- **BYZERO**: result ← 0, then → DONE next cycle.
- **DONE**
  - ready_o=1 and result_o is held.
  - start_i=0 → IDLE, with ready_o and result_o cleared.
  - start_i=1 → stay in DONE. No new operation is accepted until start_i drops.
- **annul_i** in IDLE, BYZERO or ON → IDLE next cycle, with no ready pulse and result_o unchanged at 0.
- **Arithmetic rules**
  - Results are modulo 2^DW.
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000 and remainder 0 (wraps, no trap).
- Division by zero is architecturally undefined; this block defines it as result 0.

## Timing
- Cycle T: start_i sampled in IDLE (divisor ≠ 0). ON occupies T+1 through T+32, and ready_o=1 from T+33.
- Divide by zero: BYZERO in T+1, ready_o=1 from T+2.
- stall_o is combinational and high during:
  - (IDLE && start_i && !annul_i);
  - BYZERO;
  - ON.
- stall_o is low in DONE, so the EX instruction advances the same cycle ready_o is seen.
- ready_o and result_o are registered outputs.
- annul_i is sampled every cycle. An abort in ON at step k returns to IDLE on the next edge. A fresh start is accepted in the following cycle.
- Simultaneous rst and start_i: reset wins, and the request is not captured.

## Test plan
- **Unsigned**: 100/7, signed_i=0, start at T → ready_o at T+33, result_o={0x00000002, 0x0000000E}; stall_o high T..T+32, low at T+33.
- **Signed negative**: −7/2, signed_i=1 → result_o={0xFFFFFFFF, 0xFFFFFFFD}. Also 7/−2 → {0x00000001, 0xFFFFFFFD}.
- **Divide by zero**: 0x1234/0 → ready_o at T+2, result_o=0; stall_o high T..T+1.
- **Signed overflow**: 0x80000000 / 0xFFFFFFFF, signed_i=1 → result_o={0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF/1 → {0, 0xFFFFFFFF}.
- **Annul**: annul_i at step 10 → IDLE next cycle, ready_o never asserts, stall_o low. A new start of 9/3 → {0, 3} 33 cycles later.
- **Reset and hold**:
  - rst at step 20 → next cycle all outputs 0, state IDLE.
  - Separately, holding start_i high in DONE keeps ready_o=1 and the result stable.
  - Dropping start_i returns to IDLE with ready_o=0.

Source files
------------

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Returns {remainder, quotient} after DW steps and requests a pipeline stall meanwhile.
module div_seq #(
    parameter int unsigned DW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              annul_i,
    input  logic              signed_i,
    input  logic [DW-1:0]     opdata1_i,
    input  logic [DW-1:0]     opdata2_i,
    output logic [2*DW-1:0]   result_o,
    output logic              ready_o,
    output logic              stall_o
);

    localparam int unsigned CW = $clog2(DW);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     rem_q, rem_d;
    logic [DW-1:0]     quo_q, quo_d;
    logic [DW-1:0]     dvsr_q, dvsr_d;
    logic              signed_q, signed_d;
    logic              neg_dvd_q, neg_dvd_d;
    logic              neg_quo_q, neg_quo_d;
    logic [2*DW-1:0]   result_q, result_d;
    logic              ready_q, ready_d;

    logic [DW:0]       trial;
    logic [DW-1:0]     step_rem;
    logic [DW-1:0]     step_quo;
    logic [DW-1:0]     fix_rem;
    logic [DW-1:0]     fix_quo;
    logic [DW-1:0]     op1_abs;
    logic [DW-1:0]     op2_abs;
    logic              last_step;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            signed_q  <= 1'b0;
            neg_dvd_q <= 1'b0;
            neg_quo_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            signed_q  <= signed_d;
            neg_dvd_q <= neg_dvd_d;
            neg_quo_q <= neg_quo_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    // One restoring step: subtract divisor from the shifted partial remainder
    always_comb begin
        trial     = {rem_q, quo_q[DW-1]} - {1'b0, dvsr_q};
        step_rem  = trial[DW] ? {rem_q[DW-2:0], quo_q[DW-1]} : trial[DW-1:0];
        step_quo  = {quo_q[DW-2:0], ~trial[DW]};
        fix_rem   = (signed_q && neg_dvd_q) ? -step_rem : step_rem;
        fix_quo   = (signed_q && neg_quo_q) ? -step_quo : step_quo;
        op1_abs   = (signed_i && opdata1_i[DW-1]) ? -opdata1_i : opdata1_i;
        op2_abs   = (signed_i && opdata2_i[DW-1]) ? -opdata2_i : opdata2_i;
        last_step = (cnt_q == CW'(DW - 1));
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        signed_d  = signed_q;
        neg_dvd_d = neg_dvd_q;
        neg_quo_d = neg_quo_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !annul_i) begin
                    signed_d  = signed_i;
                    neg_dvd_d = opdata1_i[DW-1];
                    neg_quo_d = opdata1_i[DW-1] ^ opdata2_i[DW-1];
                    if (opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d = S_ON;
                        cnt_d   = '0;
                        rem_d   = '0;
                        quo_d   = op1_abs;
                        dvsr_d  = op2_abs;
                    end
                end
            end
            S_BYZERO: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_DONE;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            S_ON: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CW'(1);
                    if (last_step) begin
                        state_d  = S_DONE;
                        result_d = {fix_rem, fix_quo};
                        ready_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                // Result held until EX drops its request
                if (!start_i) begin
                    state_d  = S_IDLE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign stall_o  = ((state_q == S_IDLE) && start_i && !annul_i)
                   || (state_q == S_BYZERO)
                   || (state_q == S_ON);
    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: scoreboarded divisions, annul, reset and hold behaviour.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stall_o;

    int total;
    int bad;

    logic [63:0] exp_q[$];
    int          lat_q[$];

    div_seq #(.DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .stall_o   (stall_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic signed [31:0] sa, sb, sq, sr;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            sa = a; sb = b;
            sq = sa / sb;
            sr = sa % sb;
            return {sr, sq};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    // Issue one division, wait for ready, compare with scoreboard, hold, then release
    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [63:0] exp_res, input int exp_lat);
        int          cyc;
        bit          got;
        logic [63:0] want;
        int          wlat;
        @(negedge clk);
        opdata1_i = a; opdata2_i = b; signed_i = sgn; start_i = 1'b1;
        exp_q.push_back(exp_res);
        lat_q.push_back(exp_lat);
        #1;
        total++;
        if (stall_o !== 1'b1) begin
            bad++; $display("FAIL %s stall_at_T got=%b want=1", name, stall_o);
        end
        cyc = 0; got = 0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                opdata1_i = $urandom; opdata2_i = $urandom; signed_i = ~sgn;
            end
            if (ready_o === 1'b1) got = 1;
            else begin
                total++;
                if (stall_o !== 1'b1) begin
                    bad++; $display("FAIL %s stall_busy cyc=%0d got=%b want=1", name, cyc, stall_o);
                end
            end
        end
        total++;
        if (!got) begin
            bad++; $display("FAIL %s timeout waiting for ready_o", name);
            void'(exp_q.pop_front()); void'(lat_q.pop_front());
        end else begin
            want = exp_q.pop_front();
            wlat = lat_q.pop_front();
            if (result_o !== want) begin
                bad++; $display("FAIL %s result got=%h want=%h", name, result_o, want);
            end
            total++;
            if (cyc != wlat) begin
                bad++; $display("FAIL %s latency got=%0d want=%0d", name, cyc, wlat);
            end
            total++;
            if (stall_o !== 1'b0) begin
                bad++; $display("FAIL %s stall_done got=%b want=0", name, stall_o);
            end
            for (int i = 0; i < 2; i++) begin
                @(negedge clk);
                total++;
                if (ready_o !== 1'b1 || result_o !== want) begin
                    bad++; $display("FAIL %s hold ready=%b result=%h want=1/%h", name, ready_o, result_o, want);
                end
            end
        end
        start_i = 1'b0;
        @(negedge clk);
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0 || stall_o !== 1'b0) begin
            bad++; $display("FAIL %s release ready=%b result=%h stall=%b want=0/0/0", name, ready_o, result_o, stall_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (3) @(negedge clk);
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0 || stall_o !== 1'b0) begin
            bad++; $display("FAIL reset_state ready=%b result=%h stall=%b want=0/0/0", ready_o, result_o, stall_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        run_div("udiv_100_7", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33);
        run_div("udiv_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, {32'h0, 32'hFFFF_FFFF}, 33);
    endtask

    task automatic test_signed();
        run_div("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_div("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h1, 32'hFFFF_FFFD}, 33);
        run_div("sdiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33);
    endtask

    task automatic test_byzero();
        run_div("div_zero", 32'h1234, 32'd0, 1'b0, 64'd0, 2);
        run_div("sdiv_zero", 32'h8000_0000, 32'd0, 1'b1, 64'd0, 2);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        s;
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom;
            if (i == 2) b = 32'd3 + (b & 32'hFF);
            if (b == 32'd0) b = 32'd5;
            s = i[0];
            run_div("rand", a, b, s, model(a, b, s), 33);
        end
    endtask

    task automatic test_annul();
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_i = 1'b0; start_i = 1'b1; annul_i = 1'b1;
        #1;
        total++;
        if (stall_o !== 1'b0) begin
            bad++; $display("FAIL annul_idle_stall got=%b want=0", stall_o);
        end
        @(negedge clk);
        total++;
        if (stall_o !== 1'b0 || ready_o !== 1'b0) begin
            bad++; $display("FAIL annul_idle_nocapture stall=%b ready=%b want=0/0", stall_o, ready_o);
        end
        annul_i = 1'b0;
        // Cycle T; ON step k occupies T+1+k, so step 10 is T+11
        repeat (11) @(negedge clk);
        total++;
        if (stall_o !== 1'b1) begin
            bad++; $display("FAIL annul_on_stall got=%b want=1", stall_o);
        end
        annul_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        #1;
        total++;
        if (stall_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0) begin
            bad++; $display("FAIL annul_idle stall=%b ready=%b result=%h want=0/0/0", stall_o, ready_o, result_o);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            total++;
            if (ready_o !== 1'b0 || stall_o !== 1'b0) begin
                bad++; $display("FAIL annul_quiet cyc=%0d ready=%b stall=%b want=0/0", i, ready_o, stall_o);
            end
        end
        run_div("after_annul_9_3", 32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 33);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        opdata1_i = 32'd100; opdata2_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
        repeat (21) @(negedge clk);
        total++;
        if (stall_o !== 1'b1) begin
            bad++; $display("FAIL rst_mid_busy stall=%b want=1", stall_o);
        end
        rst = 1'b1; start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0 || stall_o !== 1'b0) begin
            bad++; $display("FAIL rst_mid ready=%b result=%h stall=%b want=0/0/0", ready_o, result_o, stall_o);
        end
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            total++;
            if (ready_o !== 1'b0) begin
                bad++; $display("FAIL rst_mid_quiet cyc=%0d ready=%b want=0", i, ready_o);
            end
        end
        // Reset and start together: request must be dropped
        rst = 1'b1; start_i = 1'b1; opdata2_i = 32'd3;
        @(negedge clk);
        rst = 1'b0; start_i = 1'b0;
        @(negedge clk);
        total++;
        if (stall_o !== 1'b0 || ready_o !== 1'b0) begin
            bad++; $display("FAIL rst_start stall=%b ready=%b want=0/0", stall_o, ready_o);
        end
        run_div("after_rst_9_3", 32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 33);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_byzero();
        test_random();
        test_annul();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
